rr_arbiter_4: RTL and testbench

Round-robin arbiter that shares a single 2-to-4 decoded resource between four requesters. It selects one requester at a time and holds its grant until release or a hold-time limit. It drives the one-hot grant through the team's 2-to-4 decoder with enable. It sits between the requesting masters and the shared resource, and is the sequencing owner of the decoder's select and enable inputs.

---
 rtl/rr_arbiter_4_pkg.sv | 13 +
 rtl/rr_arbiter_4_if.sv | 33 +++
 rtl/dec2to4_en.sv | 21 ++
 rtl/rr_arbiter_4_pick.sv | 28 ++
 rtl/rr_arbiter_4.sv | 96 +++++++++
 tb/tb_rr_arbiter_4.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
interface rr_arbiter_4_if
    import rr_arbiter_4_pkg::*;
    ();

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic               timeout;

    // Requester side: drives requests and release, observes grants.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/dec2to4_en.sv
// 2-to-4 one-hot decoder with active-high enable; all-zero when disabled.
module dec2to4_en (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    // Decode select into one-hot when enabled.
    always_comb begin
        y = 4'b0000;
        if (en) begin
            case (sel)
                2'd0:    y = 4'b0001;
                2'd1:    y = 4'b0010;
                2'd2:    y = 4'b0100;
                default: y = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter_4_pick.sv
// Rotating priority picker: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import rr_arbiter_4_pkg::*;
    (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      offs;

    // Rotate so that the highest-priority requester lands on bit 0, then
    // take the lowest set bit and rotate the offset back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        if (req_rot[0])      offs = 2'd0;
        else if (req_rot[1]) offs = 2'd1;
        else if (req_rot[2]) offs = 2'd2;
        else                 offs = 2'd3;
        idx = ptr + offs;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with per-grant hold-time limit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester from ptr onward
//   ST_GRANT | gnt_id owns the resource until done, request drop or limit
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
    #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [ID_W-1:0]  gnt_id, gnt_id_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             timeout, timeout_nxt;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic             rel_done, rel_drop, rel_limit;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign rel_done  = bus.done;
    assign rel_drop  = ~bus.req[gnt_id];
    assign rel_limit = (hold_cnt == HOLD_LAST);

    // Next-state, pointer, counter and timeout decisions.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_id_nxt   = gnt_id;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt    = ST_GRANT;
                    gnt_id_nxt   = pick_idx;
                    hold_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_nxt   = ST_IDLE;
                    ptr_nxt     = gnt_id + 2'd1;
                    // Owner-initiated release wins over expiry on a tie.
                    timeout_nxt = rel_limit && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_id   <= gnt_id_nxt;
            hold_cnt <= hold_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    dec2to4_en u_dec (
        .sel (gnt_id),
        .en  (state == ST_GRANT),
        .y   (bus.gnt)
    );

    assign bus.gnt_id    = gnt_id;
    assign bus.gnt_valid = (state == ST_GRANT);
    assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4 with an independent cycle model.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_bad;
    exp_t sb_q[$];

    // model state
    logic       m_grant;
    logic [1:0] m_ptr;
    logic [1:0] m_id;
    int         m_cnt;
    logic       m_to;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0;
        m_ptr   = 2'd0;
        m_id    = 2'd0;
        m_cnt   = 0;
        m_to    = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict, compare after the edge.
    task automatic step(input logic [3:0] r, input logic d);
        exp_t e;
        exp_t got;
        logic a, b, c;
        logic found;
        logic [1:0] cand;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        m_to = 1'b0;
        if (!m_grant) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cand = m_ptr + 2'(k);
                if (!found && r[cand]) begin
                    found = 1'b1;
                    m_id  = cand;
                end
            end
            if (found) begin
                m_grant = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            a = d;
            b = !r[m_id];
            c = (m_cnt == MAX_HOLD - 1);
            if (a || b || c) begin
                m_grant = 1'b0;
                m_ptr   = m_id + 2'd1;
                m_to    = c && !a && !b;
            end else begin
                m_cnt++;
            end
        end
        e.gnt = m_grant ? (4'b0001 << m_id) : 4'b0000;
        e.id  = m_id;
        e.vld = m_grant;
        e.to  = m_to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
        end else begin
            got = sb_q.pop_front();
            chk("gnt",       {4'b0, bus.gnt},   {4'b0, got.gnt});
            chk("gnt_id",    {6'b0, bus.gnt_id}, {6'b0, got.id});
            chk("gnt_valid", {7'b0, bus.gnt_valid}, {7'b0, got.vld});
            chk("timeout",   {7'b0, bus.timeout},   {7'b0, got.to});
        end
    endtask

    int to_seen;
    int gnt_cycles;

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        model_reset();

        // reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",     {4'b0, bus.gnt}, 8'h00);
        chk("rst_gnt_vld", {7'b0, bus.gnt_valid}, 8'h00);
        chk("rst_timeout", {7'b0, bus.timeout}, 8'h00);
        chk("rst_gnt_id",  {6'b0, bus.gnt_id}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // first request: grant one cycle later
        step(4'b0001, 1'b0);
        chk("first_gnt", {4'b0, bus.gnt}, 8'h01);
        step(4'b0011, 1'b0);

        // asynchronous reset mid-grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", {4'b0, bus.gnt}, 8'h00);
        chk("midrst_vld", {7'b0, bus.gnt_valid}, 8'h00);
        chk("midrst_ptr", {6'b0, dut.ptr}, 8'h00);
        model_reset();
        bus.req = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // full contention, done on each grant's second cycle
        for (int i = 0; i < 15; i++)
            step(4'b1111, m_grant && (m_cnt == 1));
        chk("contention_ptr", {6'b0, dut.ptr}, {6'b0, m_ptr});
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // hold-time expiry on requester 2
        to_seen    = 0;
        gnt_cycles = 0;
        for (int i = 0; i < 22; i++) begin
            step(4'b0100, 1'b0);
            if (bus.timeout) to_seen++;
            if (bus.gnt == 4'b0100) gnt_cycles++;
        end
        chk("timeout_pulses", 8'(to_seen), 8'd2);
        chk("timeout_gnt_cycles", 8'(gnt_cycles), 8'd20);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // pointer wrap: after owner 2, 1001 picks 3 then 0
        step(4'b1001, 1'b0);
        chk("wrap_first", {4'b0, bus.gnt}, 8'h08);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b0);
        chk("wrap_second", {4'b0, bus.gnt}, 8'h01);
        step(4'b1001, 1'b1);
        step(4'b0000, 1'b0);

        // request drop while granted 0010
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("drop_ptr", {6'b0, dut.ptr}, 8'h02);

        // done coincides with the hold limit: no timeout
        for (int i = 0; i < 10; i++)
            step(4'b1000, m_grant && (m_cnt == MAX_HOLD - 1));
        step(4'b0000, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        chk("rand_ptr", {6'b0, dut.ptr}, {6'b0, m_ptr});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
